// File: rtl/mul_hilo_sequencer.sv
// Multi-cycle unsigned shift-add multiplier with HI/LO result registers.
// Raises Stall to hold the control FSM until the product is committed.
module mul_hilo_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             RdReq,
   input  logic             HiLoSel,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] HiLoOut
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]    p_q, p_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [PW-1:0]    addend;

   assign addend = {{WIDTH{1'b0}}, a_q} << cnt_q;

   // Next-state logic: operand capture, one shift-add step per RUN cycle, commit in DONE
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               a_d     = OpA;
               b_d     = OpB;
               p_d     = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (b_q[0]) begin
               p_d = p_q + addend;
            end
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            hi_d    = p_q[PW-1:WIDTH];
            lo_d    = p_q[WIDTH-1:0];
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset aborts any multiply in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Stall covers issue and RUN; a read pending in DONE is served by the P bypass
   always_comb begin
      Stall = (Start & (state_q == S_IDLE))
            | (state_q == S_RUN)
            | (RdReq & busy_q & ~done_q);
   end

   // Read mux: in DONE the not-yet-committed product is forwarded
   always_comb begin
      if (done_q) begin
         HiLoOut = HiLoSel ? p_q[PW-1:WIDTH] : p_q[WIDTH-1:0];
      end else begin
         HiLoOut = HiLoSel ? hi_q : lo_q;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Directed bench for mul_hilo_sequencer (WIDTH=16).
// Inputs change 1ns after posedge; outputs are observed on negedge.
module tb_mul_hilo_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Start = 1'b0;
   logic [15:0] OpA = '0;
   logic [15:0] OpB = '0;
   logic        RdReq = 1'b0;
   logic        HiLoSel = 1'b0;
   logic        Stall, Busy, Done;
   logic [15:0] HI, LO, HiLoOut;

   int total = 0;
   int bad = 0;

   mul_hilo_sequencer #(.WIDTH(16)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .OpA(OpA), .OpB(OpB),
      .RdReq(RdReq), .HiLoSel(HiLoSel), .Stall(Stall), .Busy(Busy),
      .Done(Done), .HI(HI), .LO(LO), .HiLoOut(HiLoOut)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Issue one multiply and observe it; done_at=-1 if no Done within budget
   task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                         output int done_at, output int stalls,
                         output logic stall_at_done);
      done_at = -1;
      stalls = 0;
      stall_at_done = 1'b1;
      Start = 1'b1; OpA = a; OpB = b;
      @(negedge CLK);
      if (Stall) stalls++;
      step();
      Start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (Done) begin
            done_at = c;
            stall_at_done = Stall;
            break;
         end
         if (Stall) stalls++;
         step();
      end
      step();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      @(negedge CLK);
      total++;
      if (HI !== 16'h0 || LO !== 16'h0) begin
         bad++;
         $display("FAIL reset_hilo: got HI=%h LO=%h want 0/0", HI, LO);
      end
      total++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl: got Busy=%b Done=%b Stall=%b want 000",
                  Busy, Done, Stall);
      end
      step();
   endtask

   task automatic test_basic();
      int d, s;
      logic sd;
      do_mul(16'd3, 16'd5, d, s, sd);
      total++;
      if (d !== 17) begin
         bad++;
         $display("FAIL basic_latency: got %0d want 17", d);
      end
      total++;
      if (s !== 17 || sd !== 1'b0) begin
         bad++;
         $display("FAIL basic_stall: got cycles=%0d at_done=%b want 17/0", s, sd);
      end
      total++;
      if (LO !== 16'h000F || HI !== 16'h0000 || Busy !== 1'b0 || Done !== 1'b0) begin
         bad++;
         $display("FAIL basic_result: got HI=%h LO=%h Busy=%b Done=%b want 0000 000f 0 0",
                  HI, LO, Busy, Done);
      end
   endtask

   task automatic test_extremes();
      int d, s;
      logic sd;
      do_mul(16'hFFFF, 16'hFFFF, d, s, sd);
      total++;
      if (d !== 17 || HI !== 16'hFFFE || LO !== 16'h0001) begin
         bad++;
         $display("FAIL max_operands: got lat=%0d HI=%h LO=%h want 17 fffe 0001", d, HI, LO);
      end
      do_mul(16'h0000, 16'hFFFF, d, s, sd);
      total++;
      if (d !== 17 || HI !== 16'h0 || LO !== 16'h0) begin
         bad++;
         $display("FAIL zero_operand: got lat=%0d HI=%h LO=%h want 17 0000 0000", d, HI, LO);
      end
   endtask

   task automatic test_start_while_busy();
      int d;
      int d2, s2;
      logic sd2;
      d = -1;
      Start = 1'b1; OpA = 16'd3; OpB = 16'd5;
      step();
      Start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         Start = (c == 4);
         OpA = (c == 4) ? 16'd7 : 16'd0;
         OpB = (c == 4) ? 16'd7 : 16'd0;
         @(negedge CLK);
         if (Done) begin
            d = c;
            break;
         end
         step();
      end
      Start = 1'b0;
      step();
      total++;
      if (d !== 17 || LO !== 16'h000F || HI !== 16'h0) begin
         bad++;
         $display("FAIL ignore_start: got lat=%0d HI=%h LO=%h want 17 0000 000f", d, HI, LO);
      end
      do_mul(16'd7, 16'd7, d2, s2, sd2);
      total++;
      if (d2 !== 17 || LO !== 16'h0031) begin
         bad++;
         $display("FAIL next_start: got lat=%0d LO=%h want 17 0031", d2, LO);
      end
   endtask

   task automatic test_reset_abort();
      int dones;
      int d, s;
      logic sd;
      dones = 0;
      Start = 1'b1; OpA = 16'h1234; OpB = 16'h0100;
      step();
      Start = 1'b0;
      for (int c = 1; c < 8; c++) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      @(negedge CLK);
      total++;
      if (Busy !== 1'b0 || HI !== 16'h0 || LO !== 16'h0 || Stall !== 1'b0) begin
         bad++;
         $display("FAIL abort_state: got Busy=%b HI=%h LO=%h Stall=%b want 0 0000 0000 0",
                  Busy, HI, LO, Stall);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (Done) dones++;
      end
      step();
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL abort_no_done: got %0d pulses want 0", dones);
      end
      do_mul(16'd2, 16'd2, d, s, sd);
      total++;
      if (d !== 17 || LO !== 16'h0004 || HI !== 16'h0) begin
         bad++;
         $display("FAIL after_abort: got lat=%0d HI=%h LO=%h want 17 0000 0004", d, HI, LO);
      end
   endtask

   task automatic test_read();
      int d, s;
      logic sd;
      int stalls, done_at;
      logic [15:0] mid_out, done_out, done_hi;
      logic done_stall;
      do_mul(16'h1234, 16'h0100, d, s, sd);
      total++;
      if (HI !== 16'h0012 || LO !== 16'h3400) begin
         bad++;
         $display("FAIL read_setup: got HI=%h LO=%h want 0012 3400", HI, LO);
      end
      RdReq = 1'b1; HiLoSel = 1'b1;
      @(negedge CLK);
      total++;
      if (HiLoOut !== 16'h0012 || Stall !== 1'b0) begin
         bad++;
         $display("FAIL idle_read_hi: got out=%h Stall=%b want 0012 0", HiLoOut, Stall);
      end
      step();
      HiLoSel = 1'b0;
      @(negedge CLK);
      total++;
      if (HiLoOut !== 16'h3400 || Stall !== 1'b0) begin
         bad++;
         $display("FAIL idle_read_lo: got out=%h Stall=%b want 3400 0", HiLoOut, Stall);
      end
      step();
      // Start and read together: 0xFFFF*2 = 0x0001_FFFE
      HiLoSel = 1'b1;
      Start = 1'b1; OpA = 16'hFFFF; OpB = 16'h0002;
      stalls = 0; done_at = -1;
      mid_out = 'x; done_out = 'x; done_hi = 'x; done_stall = 1'bx;
      @(negedge CLK);
      if (Stall) stalls++;
      step();
      Start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (c == 8) mid_out = HiLoOut;
         if (Done) begin
            done_at = c;
            done_out = HiLoOut;
            done_hi = HI;
            done_stall = Stall;
            break;
         end
         if (Stall) stalls++;
         step();
      end
      step();
      RdReq = 1'b0;
      total++;
      if (stalls !== 17 || done_at !== 17) begin
         bad++;
         $display("FAIL busy_read_stall: got stalls=%0d done=%0d want 17 17", stalls, done_at);
      end
      total++;
      if (mid_out !== 16'h0012) begin
         bad++;
         $display("FAIL busy_read_committed: got %h want 0012", mid_out);
      end
      total++;
      if (done_out !== 16'h0001 || done_hi !== 16'h0012 || done_stall !== 1'b0) begin
         bad++;
         $display("FAIL done_bypass: got out=%h HI=%h Stall=%b want 0001 0012 0",
                  done_out, done_hi, done_stall);
      end
      total++;
      if (HI !== 16'h0001 || LO !== 16'hFFFE) begin
         bad++;
         $display("FAIL bypass_commit: got HI=%h LO=%h want 0001 fffe", HI, LO);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_start_while_busy();
      test_reset_abort();
      test_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
